digit_scan_ctrl: RTL and testbench



---
 rtl/digit_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Digit scan sequencer for a 3-to-8 one-hot decoder.
// It steps idx through 0..last with a programmable on-time and a fixed blanking gap.
module digit_scan_ctrl #(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  input  logic [2:0]       last_idx,
  output logic [2:0]       idx,
  output logic             en,
  output logic             frame_done,
  output logic             busy
);

  localparam int BW = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             en_q, en_d;
  logic             frameDone_q, frameDone_d;
  logic             busy_q, busy_d;
  logic [2:0]       last_q, last_d;
  logic [DIV_W-1:0] onCnt_q, onCnt_d;
  logic [BW-1:0]    blankCnt_q, blankCnt_d;

  logic [DIV_W-1:0] periodEff;
  logic             advance;

  assign periodEff = (period == '0) ? DIV_W'(1) : period;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    en_d        = en_q;
    frameDone_d = 1'b0;
    busy_d      = busy_q;
    last_d      = last_q;
    onCnt_d     = onCnt_q;
    blankCnt_d  = blankCnt_q;
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        idx_d = 3'd0;
        if (run) begin
          state_d = ACTIVE;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          last_d  = last_idx;
          onCnt_d = periodEff;
        end
      end
      ACTIVE: begin
        if (onCnt_q <= DIV_W'(1)) begin
          if (BLANK_CYC > 0) begin
            state_d    = BLANK;
            en_d       = 1'b0;
            blankCnt_d = BLANK_LOAD;
          end else begin
            advance = 1'b1;
          end
        end else begin
          onCnt_d = onCnt_q - DIV_W'(1);
        end
      end
      BLANK: begin
        if (blankCnt_q <= BW'(1)) begin
          advance = 1'b1;
        end else begin
          blankCnt_d = blankCnt_q - BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // The wrap to digit 0 only happens at the latched last index, so idx never overflows.
    if (advance) begin
      if (idx_q != last_q) begin
        state_d = ACTIVE;
        idx_d   = idx_q + 3'd1;
        en_d    = 1'b1;
        onCnt_d = periodEff;
      end else begin
        idx_d       = 3'd0;
        frameDone_d = 1'b1;
        if (run) begin
          state_d = ACTIVE;
          en_d    = 1'b1;
          last_d  = last_idx;
          onCnt_d = periodEff;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          onCnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      en_q        <= 1'b0;
      frameDone_q <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 3'd0;
      onCnt_q     <= '0;
      blankCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      frameDone_q <= frameDone_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      onCnt_q     <= onCnt_d;
      blankCnt_q  <= blankCnt_d;
    end
  end

  assign idx        = idx_q;
  assign en         = en_q;
  assign frame_done = frameDone_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: a BLANK_CYC=2 instance and a BLANK_CYC=0 instance
// share stimulus; each scenario checks only the instance it targets.
module tb_digit_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] period;
  logic [2:0]  last_idx;

  logic [2:0]  idx, idx0;
  logic        en, en0;
  logic        frameDone, frameDone0;
  logic        busy, busy0;

  int nCompared;
  int nMismatched;

  digit_scan_ctrl #(.DIV_W(16), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .run(run), .period(period), .last_idx(last_idx),
    .idx(idx), .en(en), .frame_done(frameDone), .busy(busy)
  );

  digit_scan_ctrl #(.DIV_W(16), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .period(period), .last_idx(last_idx),
    .idx(idx0), .en(en0), .frame_done(frameDone0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] p, input logic [2:0] last);
    rst      = 1'b1;
    run      = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    period   = p;
    last_idx = last;
    run      = 1'b1;
  endtask

  task automatic checkMain(input string tag, input int c, input int eIdx, input int eEn, input int eFd, input int eBusy);
    checkOutput($sformatf("%s idx c%0d", tag, c), 32'(idx), 32'(eIdx));
    checkOutput($sformatf("%s en c%0d", tag, c), 32'(en), 32'(eEn));
    checkOutput($sformatf("%s frame_done c%0d", tag, c), 32'(frameDone), 32'(eFd));
    checkOutput($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(eBusy));
  endtask

  initial begin
    int periodPat[12];
    int idxPat[12];
    nCompared   = 0;
    nMismatched = 0;
    rst      = 1'b1;
    run      = 1'b0;
    period   = 16'd3;
    last_idx = 3'd2;
    tick();
    checkMain("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    checkMain("idle", 0, 0, 0, 0, 0);

    // Basic scan: P=3, gap=2, three digits, 15-cycle frames.
    applyStimulus(16'd3, 3'd2);
    for (int c = 0; c < 32; c++) begin
      tick();
      checkMain("basic", c, (c / 5) % 3, ((c % 5) < 3) ? 1 : 0, (c > 0 && c % 15 == 0) ? 1 : 0, 1);
    end

    // Drop run during digit 1: the frame completes, then IDLE.
    applyStimulus(16'd3, 3'd2);
    for (int c = 0; c < 18; c++) begin
      tick();
      if (c < 15)
        checkMain("stop", c, (c / 5) % 3, ((c % 5) < 3) ? 1 : 0, 0, 1);
      else
        checkMain("stop", c, 0, 0, (c == 15) ? 1 : 0, 0);
      if (c == 6) run = 1'b0;
    end

    // period=0 behaves as 1, single-digit frame of 3 cycles.
    applyStimulus(16'd0, 3'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkMain("p0", c, 0, (c % 3 == 0) ? 1 : 0, (c > 0 && c % 3 == 0) ? 1 : 0, 1);
    end

    // last_idx=7 walks all eight digits and wraps only at frame end.
    applyStimulus(16'd1, 3'd7);
    for (int c = 0; c < 28; c++) begin
      tick();
      checkMain("last7", c, (c / 3) % 8, (c % 3 == 0) ? 1 : 0, (c == 24) ? 1 : 0, 1);
    end

    // No-gap build: en stays high, idx steps every 2 cycles, frame every 8.
    applyStimulus(16'd2, 3'd3);
    for (int c = 0; c < 18; c++) begin
      tick();
      checkOutput($sformatf("nogap idx c%0d", c), 32'(idx0), 32'((c / 2) % 4));
      checkOutput($sformatf("nogap en c%0d", c), 32'(en0), 32'd1);
      checkOutput($sformatf("nogap frame_done c%0d", c), 32'(frameDone0), (c > 0 && c % 8 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("nogap busy c%0d", c), 32'(busy0), 32'd1);
    end

    // last_idx 5->1 during digit 2: this frame still reaches 5, next frame is 0..1.
    applyStimulus(16'd1, 3'd5);
    for (int c = 0; c < 26; c++) begin
      tick();
      if (c < 18)
        checkMain("lastchg", c, c / 3, (c % 3 == 0) ? 1 : 0, 0, 1);
      else
        checkMain("lastchg", c, ((c - 18) / 3) % 2, (c % 3 == 0) ? 1 : 0, (c == 18 || c == 24) ? 1 : 0, 1);
      if (c == 7) last_idx = 3'd1;
    end

    // period 3->1 during digit 0: digit 0 keeps 3 cycles, later digits use 1.
    periodPat = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    idxPat    = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    applyStimulus(16'd3, 3'd2);
    for (int c = 0; c < 12; c++) begin
      tick();
      checkMain("perchg", c, idxPat[c], periodPat[c], (c == 11) ? 1 : 0, 1);
      if (c == 1) period = 16'd1;
    end

    // Reset during the gap of digit 4, then restart with run still high.
    applyStimulus(16'd1, 3'd5);
    for (int c = 0; c < 14; c++) begin
      tick();
      checkMain("rstmid", c, c / 3, (c % 3 == 0) ? 1 : 0, 0, 1);
    end
    rst = 1'b1;
    tick();
    checkMain("rstmid reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkMain("restart", c, c / 3, (c % 3 == 0) ? 1 : 0, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
